floating_point_core: RTL and testbench

FLOATING_POINT_CORE -- requirements
Module: floating_point_core

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_norm_round.sv | 57 +++++
 rtl/floating_point_core.sv | 161 ++++++++++++++++
 tb/tb_floating_point_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the single-precision core
package fp_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int WORD_W = SIGN_W + EXP_W + FRAC_W;
  localparam int BIAS   = 127;

  localparam logic [WORD_W-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, MUL, NORM, ROUND, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_RSVD = 2'b11} op_t;
endpackage

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - normalize (lzc / carry shift) and round-to-nearest-even with packing
module fp_norm_round
  import fp_pkg::*;
(
  input  logic [27:0]        sum,
  input  logic signed [9:0]  exp_in,
  output logic [26:0]        norm_sig,
  output logic signed [9:0]  norm_exp,
  output logic               norm_zero,
  input  logic [26:0]        rnd_sig,
  input  logic signed [9:0]  rnd_exp,
  input  logic               rnd_sign,
  input  logic               rnd_zero,
  output logic [WORD_W-1:0]  result
);
  logic [4:0]         lz;
  logic [23:0]        mant;
  logic               round_up;
  logic [24:0]        rounded;
  logic [FRAC_W-1:0]  frac;
  logic signed [9:0]  exp_f;

  // Leading one sits at bit 26; bit 27 is the adder/multiplier carry.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    norm_zero = (sum == 28'd0);
    if (sum[27]) begin
      norm_sig = {sum[27:2], sum[1] | sum[0]};
      norm_exp = exp_in + 10'sd1;
    end else begin
      norm_sig = sum[26:0] << lz;
      norm_exp = exp_in - $signed({5'd0, lz});
    end
  end

  always_comb begin
    mant     = rnd_sig[26:3];
    round_up = rnd_sig[2] & (rnd_sig[1] | rnd_sig[0] | mant[0]);
    rounded  = {1'b0, mant} + {24'd0, round_up};
    if (rounded[24]) begin
      frac  = rounded[23:1];
      exp_f = rnd_exp + 10'sd1;
    end else begin
      frac  = rounded[22:0];
      exp_f = rnd_exp;
    end
    if (rnd_zero || exp_f <= 10'sd0)
      result = {rnd_sign, 31'd0};
    else if (exp_f >= 10'sd255)
      result = {rnd_sign, 8'hFF, 23'd0};
    else
      result = {rnd_sign, exp_f[7:0], frac};
  end
endmodule

// File: rtl/floating_point_core.sv
// rtl/floating_point_core.sv - multi-cycle IEEE-754 single add/sub/mul with control FSM
module floating_point_core
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WORD_W-1:0]  A,
  input  logic [WORD_W-1:0]  B,
  output logic [WORD_W-1:0]  R,
  output logic               done
);
  state_t             state;
  logic [WORD_W-1:0]  a_r, b_r;
  logic [1:0]         op_r;
  logic [4:0]         cnt;
  logic [47:0]        prod;
  logic [26:0]        big_sig, small_sig, norm_sig_r;
  logic [27:0]        sum_r;
  logic signed [9:0]  exp_r, norm_exp_r;
  logic               sign_r, eff_sub_r, norm_zero_r;

  logic [EXP_W-1:0]   ea, eb, diff;
  logic [FRAC_W:0]    sig_a, sig_b;
  logic               sb_eff, a_big;
  logic [26:0]        small_x, aligned;
  logic [52:0]        shifted;
  logic [27:0]        add_sum;
  logic [24:0]        mul_upper;
  logic [26:0]        norm_sig;
  logic signed [9:0]  norm_exp;
  logic               norm_zero;
  logic [WORD_W-1:0]  rnd_result, special_val;
  logic               special;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea      = a_r[30:23];
  assign eb      = b_r[30:23];
  assign a_zero  = (ea == 8'd0);
  assign b_zero  = (eb == 8'd0);
  assign a_nan   = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
  assign a_inf   = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
  assign sig_a   = a_zero ? 24'd0 : {1'b1, a_r[22:0]};
  assign sig_b   = b_zero ? 24'd0 : {1'b1, b_r[22:0]};
  assign sb_eff  = b_r[31] ^ (op_r == OP_SUB);

  // Alignment: bits pushed past the sticky position are OR-ed into it.
  assign a_big   = {ea, sig_a[22:0]} >= {eb, sig_b[22:0]};
  assign diff    = a_big ? (ea - eb) : (eb - ea);
  assign small_x = {a_big ? sig_b : sig_a, 3'b000};
  assign shifted = {small_x, 26'd0} >> diff;
  assign aligned = (diff >= 8'd26) ? {26'd0, |small_x}
                                   : {shifted[52:27], shifted[26] | (|shifted[25:0])};

  assign add_sum   = eff_sub_r ? ({1'b0, big_sig} - {1'b0, small_sig})
                               : ({1'b0, big_sig} + {1'b0, small_sig});
  assign mul_upper = {1'b0, prod[47:24]} + (prod[0] ? {1'b0, sig_a} : 25'd0);

  always_comb begin
    special     = 1'b1;
    special_val = CANON_NAN;
    if (a_nan || b_nan) begin
      special_val = CANON_NAN;
    end else if (op_r == OP_MUL) begin
      if ((a_inf && b_zero) || (b_inf && a_zero)) special_val = CANON_NAN;
      else if (a_inf || b_inf) special_val = {a_r[31] ^ b_r[31], 8'hFF, 23'd0};
      else special = 1'b0;
    end else begin
      if (a_inf && b_inf && (a_r[31] != sb_eff)) special_val = CANON_NAN;
      else if (a_inf) special_val = {a_r[31], 8'hFF, 23'd0};
      else if (b_inf) special_val = {sb_eff, 8'hFF, 23'd0};
      else special = 1'b0;
    end
  end

  fp_norm_round u_norm_round (
    .sum       (sum_r),
    .exp_in    (exp_r),
    .norm_sig  (norm_sig),
    .norm_exp  (norm_exp),
    .norm_zero (norm_zero),
    .rnd_sig   (norm_sig_r),
    .rnd_exp   (norm_exp_r),
    .rnd_sign  (sign_r),
    .rnd_zero  (norm_zero_r),
    .result    (rnd_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= 2'b00;
      cnt         <= 5'd0;
      prod        <= '0;
      big_sig     <= '0;
      small_sig   <= '0;
      sum_r       <= '0;
      norm_sig_r  <= '0;
      exp_r       <= '0;
      norm_exp_r  <= '0;
      sign_r      <= 1'b0;
      eff_sub_r   <= 1'b0;
      norm_zero_r <= 1'b0;
      R           <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r    <= A;
          b_r    <= B;
          op_r   <= op;
          cnt    <= 5'd0;
          prod   <= {24'd0, (B[30:23] == 8'd0) ? 24'd0 : {1'b1, B[22:0]}};
          exp_r  <= $signed({2'b00, A[30:23]}) + $signed({2'b00, B[30:23]}) - 10'(BIAS);
          sign_r <= A[31] ^ B[31];
          state  <= (op == OP_MUL) ? MUL : ALIGN;
        end
        ALIGN: begin
          big_sig   <= {a_big ? sig_a : sig_b, 3'b000};
          small_sig <= aligned;
          exp_r     <= $signed({2'b00, a_big ? ea : eb});
          sign_r    <= a_big ? a_r[31] : sb_eff;
          eff_sub_r <= a_r[31] ^ sb_eff;
          state     <= ADD;
        end
        ADD: begin
          sum_r <= add_sum;
          if (add_sum == 28'd0) sign_r <= 1'b0;
          state <= NORM;
        end
        // 24 shift-add steps, then one cycle to repack the product for NORM.
        MUL: if (cnt == 5'd24) begin
          sum_r <= {prod[47:21], prod[20] | (|prod[19:0])};
          state <= NORM;
        end else begin
          prod <= {mul_upper, prod[23:1]};
          cnt  <= cnt + 5'd1;
        end
        NORM: begin
          norm_sig_r  <= norm_sig;
          norm_exp_r  <= norm_exp;
          norm_zero_r <= norm_zero;
          state       <= ROUND;
        end
        ROUND: begin
          R     <= special ? special_val : rnd_result;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_point_core.sv
// tb/tb_floating_point_core.sv - scoreboard bench with an exact-integer reference model
module tb_floating_point_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] R;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] r;
    int          t0;
    int          lat;
  } exp_t;
  exp_t q[$];

  floating_point_core dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .R     (R),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round an exact integer magnitude v (value v * 2^(base-150)) to a single.
  function automatic logic [31:0] pack_round(input logic sign, input logic [127:0] v, input int base);
    int p, sh, e;
    logic [127:0] keep, rem, half;
    if (v == 128'd0) return {sign, 31'd0};
    p = 0;
    for (int i = 0; i < 128; i++) if (v[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      keep = v >> sh;
      rem  = v & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
      if (keep[24]) begin
        keep = keep >> 1;
        p = p + 1;
      end
    end else begin
      keep = v << (23 - p);
    end
    e = base + p - 23;
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    if (e <= 0) return {sign, 31'd0};
    return {sign, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] ref_fp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    int ea, eb, eau, ebu, emin;
    logic sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [127:0] ma, mb, va, vb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ (o == 2'b01);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    ma = a_zero ? 128'd0 : {104'd0, 1'b1, a[22:0]};
    mb = b_zero ? 128'd0 : {104'd0, 1'b1, b[22:0]};
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (o == 2'b10) begin
      if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
      if (a_inf || b_inf) return {a[31] ^ b[31], 8'hFF, 23'd0};
      return pack_round(a[31] ^ b[31], ma * mb, ea + eb - 127 - 23);
    end
    if (a_inf && b_inf) return (sa != sb) ? 32'h7FC0_0000 : {sa, 8'hFF, 23'd0};
    if (a_inf) return {sa, 8'hFF, 23'd0};
    if (b_inf) return {sb, 8'hFF, 23'd0};
    eau  = a_zero ? eb : ea;
    ebu  = b_zero ? ea : eb;
    emin = (eau < ebu) ? eau : ebu;
    va = ma << (eau - emin);
    vb = mb << (ebu - emin);
    if (sa == sb) return pack_round(sa, va + vb, emin);
    if (va == vb) return 32'd0;
    if (va > vb) return pack_round(sa, va - vb, emin);
    return pack_round(sb, vb - va, emin);
  endfunction

  function automatic logic [31:0] gen(input bit wide);
    int k;
    logic [22:0] f;
    logic [7:0] e;
    k = $urandom_range(0, 11);
    f = 23'($urandom);
    if (k == 0) e = 8'd0;
    else if (k == 1) begin e = 8'hFF; f = 23'd0; end
    else if (k == 2) begin e = 8'hFF; f[0] = 1'b1; end
    else e = wide ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 150));
    return {1'($urandom), e, f};
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d R=%h, no operation outstanding", cyc, R);
      end else begin
        e = q.pop_front();
        checks += 2;
        if (R !== e.r) begin
          errors++;
          $display("FAIL result R=%h expected %h", R, e.r);
        end
        if (cyc - e.t0 != e.lat) begin
          errors++;
          $display("FAIL latency got %0d expected %0d", cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                        input logic [31:0] expect_r, input bit poke);
    @(negedge clk);
    A = a;
    B = b;
    op = o;
    start = 1'b1;
    q.push_back(exp_t'{r: expect_r, t0: cyc, lat: (o == 2'b10) ? 28 : 5});
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    op = 2'($urandom);
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout no done for A=%h B=%h op=%0d", a, b, o);
      void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic check_idle_state(input string name);
    checks += 2;
    if (R !== 32'd0) begin
      errors++;
      $display("FAIL %s_R R=%h expected 00000000", name, R);
    end
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done done=%b expected 0", name, done);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0] o;
    int pulses;
    repeat (3) @(negedge clk);
    check_idle_state("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h3FC0_0000, 32'h4010_0000, 2'b00, 32'h4070_0000, 1'b0);
    run_op(32'h40A0_0000, 32'h4040_0000, 2'b01, 32'h4000_0000, 1'b1);
    run_op(32'h3F80_0000, 32'h3F80_0000, 2'b01, 32'h0000_0000, 1'b0);
    run_op(32'h3F80_0000, 32'h3380_0000, 2'b00, 32'h3F80_0000, 1'b0);
    run_op(32'h3F80_0001, 32'h3380_0000, 2'b00, 32'h3F80_0002, 1'b0);
    run_op(32'h7F7F_FFFF, 32'h4000_0000, 2'b10, 32'h7F80_0000, 1'b0);
    run_op(32'h7F80_0000, 32'hFF80_0000, 2'b00, 32'h7FC0_0000, 1'b0);
    run_op(32'h0000_0000, 32'h7F80_0000, 2'b10, 32'h7FC0_0000, 1'b0);
    run_op(32'h3FC0_0000, 32'h4010_0000, 2'b11, 32'h4070_0000, 1'b0);
    run_op(32'h4040_0000, 32'hC000_0000, 2'b10, 32'hC0C0_0000, 1'b1);

    // Abort a multiply in its 10th MUL cycle.
    @(negedge clk);
    A = 32'h4040_0000;
    B = 32'h4040_0000;
    op = 2'b10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_state("abort");
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_done pulses=%0d expected 0", pulses);
    end
    run_op(32'h4040_0000, 32'h4040_0000, 2'b10, 32'h4110_0000, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    op = 2'b00;
    A = 32'h3F80_0000;
    B = 32'h3F80_0000;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_idle_state("rst_prio");
    repeat (10) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom);
      a = gen(o == 2'b10);
      b = gen(o == 2'b10);
      if ($urandom_range(0, 7) == 0) b = a ^ {1'($urandom), 31'd0};
      run_op(a, b, o, ref_fp(a, b, o), 1'($urandom));
    end

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_queue size=%0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
